// File: rtl/io_bank_if.sv
// io_bank_if: config, core-side and pad-side signal bundle for io_bank_ctrl
interface io_bank_if #(
  parameter int NUM_IO     = 8,
  parameter int CONF_WIDTH = 3
);
  localparam int CFG_W = 4 + CONF_WIDTH;
  localparam int AW    = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  logic                         cfg_we;
  logic [AW-1:0]                cfg_addr;
  logic [CFG_W-1:0]             cfg_wdata;
  logic [CFG_W-1:0]             cfg_rdata;
  logic [NUM_IO-1:0]            core_out;
  logic [NUM_IO-1:0]            core_oe;
  logic [NUM_IO-1:0]            core_in;
  logic [NUM_IO-1:0]            irq_clr;
  logic [NUM_IO-1:0]            irq_pending;
  logic                         irq;
  logic [NUM_IO-1:0]            pad_out;
  logic [NUM_IO-1:0]            pad_oe;
  logic [NUM_IO-1:0]            pad_in;
  logic [NUM_IO*CONF_WIDTH-1:0] pad_cfg;
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, core_out, core_oe, irq_clr, pad_in,
    output cfg_rdata, core_in, irq_pending, irq, pad_out, pad_oe, pad_cfg
  );
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, core_out, core_oe, irq_clr, pad_in,
    input  cfg_rdata, core_in, irq_pending, irq, pad_out, pad_oe, pad_cfg
  );
endinterface

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: per-channel pad muxing, input sync/glitch filter and edge interrupts
module io_bank_ctrl #(
  parameter int NUM_IO     = 8,
  parameter int CONF_WIDTH = 3,
  parameter int FILT_LEN   = 4
) (
  input logic      clk,
  input logic      rst,
  io_bank_if.slave io
);
  localparam int CFG_W = 4 + CONF_WIDTH;
  localparam int AW    = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int CW    = $clog2(FILT_LEN);

  logic [CFG_W-1:0]             r_cfg [NUM_IO];
  logic [CW-1:0]                r_cnt [NUM_IO];
  logic [NUM_IO-1:0]            r_s1, r_s2, r_filt, r_core_in, r_prev, r_pend, r_pad_out, r_pad_oe;
  logic [NUM_IO-1:0]            w_sel, w_wclr, w_m0, w_m1, w_fe, w_ie;
  logic [NUM_IO*CONF_WIDTH-1:0] w_pad_cfg;
  logic                         w_ok;

  assign w_ok = {1'b0, io.cfg_addr} < (AW+1)'(NUM_IO);

  always_comb begin
    w_sel     = '0;
    w_wclr    = '0;
    w_m0      = '0;
    w_m1      = '0;
    w_fe      = '0;
    w_ie      = '0;
    w_pad_cfg = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      w_sel[i]  = w_ok && io.cfg_we && io.cfg_addr == AW'(i);
      w_wclr[i] = w_sel[i] && !io.cfg_wdata[3];
      w_m0[i]   = r_cfg[i][0];
      w_m1[i]   = r_cfg[i][1];
      w_fe[i]   = r_cfg[i][2];
      w_ie[i]   = r_cfg[i][3];
      w_pad_cfg[i*CONF_WIDTH +: CONF_WIDTH] = r_cfg[i][CFG_W-1:4];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IO; i++) begin
      if (rst) begin
        r_cfg[i]  <= '0;
        r_cnt[i]  <= '0;
        r_filt[i] <= 1'b0;
      end else begin
        if (w_sel[i]) r_cfg[i] <= io.cfg_wdata;
        if (!w_fe[i]) begin
          r_filt[i] <= r_s2[i];
          r_cnt[i]  <= '0;
        end else if (r_s2[i] == r_filt[i]) begin
          r_cnt[i]  <= '0;
        end else if (r_cnt[i] == CW'(FILT_LEN-1)) begin
          r_filt[i] <= r_s2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i]  <= r_cnt[i] + 1'b1;
        end
      end
    end
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_core_in <= '0;
      r_prev    <= '0;
      r_pend    <= '0;
      r_pad_out <= '0;
      r_pad_oe  <= '0;
    end else begin
      r_s1      <= io.pad_in;
      r_s2      <= r_s1;
      r_pad_oe  <= w_m0 & (~w_m1 | io.core_oe);
      r_pad_out <= w_m0 & io.core_out;
      r_core_in <= w_m1 & ((w_fe & r_filt) | (~w_fe & r_s2));
      r_prev    <= r_core_in;
      // config write with irq_en=0 beats a new edge, which beats irq_clr
      r_pend    <= ~w_wclr & ((w_ie & (r_core_in ^ r_prev)) | (r_pend & ~io.irq_clr));
    end
  end

  assign io.cfg_rdata   = w_ok ? r_cfg[io.cfg_addr] : '0;
  assign io.core_in     = r_core_in;
  assign io.irq_pending = r_pend;
  assign io.irq         = |r_pend;
  assign io.pad_out     = r_pad_out;
  assign io.pad_oe      = r_pad_oe;
  assign io.pad_cfg     = w_pad_cfg;
endmodule

// File: tb/tb_io_bank_ctrl.sv
// tb_io_bank_ctrl: directed and randomized checks of io_bank_ctrl against a behavioural model
module tb_io_bank_ctrl;
  localparam int N     = 6;
  localparam int CONFW = 3;
  localparam int FL    = 4;
  localparam int CFG_W = 4 + CONFW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  io_bank_if #(.NUM_IO(N), .CONF_WIDTH(CONFW)) bus ();

  io_bank_ctrl #(.NUM_IO(N), .CONF_WIDTH(CONFW), .FILT_LEN(FL)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus.slave)
  );

  always #5 clk = ~clk;

  logic [CFG_W-1:0] m_cfg [N];
  logic [FL-1:0]    m_s2w [N];
  logic [FL-1:0]    m_enw [N];
  logic [N-1:0]     m_s1, m_s2, m_fv, m_ci, m_prev, m_pend, m_po, m_poe;

  task automatic step();
    logic [N-1:0] n_po, n_poe, n_ci, n_pend, n_fv;
    logic [1:0]   md;
    logic         fe, ie, hit, wclr;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cfg[i] = '0;
        m_s2w[i] = '0;
        m_enw[i] = '0;
      end
      {m_s1, m_s2, m_fv, m_ci, m_prev, m_pend, m_po, m_poe} = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        md = m_cfg[i][1:0];
        fe = m_cfg[i][2];
        ie = m_cfg[i][3];
        n_poe[i] = (md == 2'b01) ? 1'b1 : (md == 2'b11) ? bus.core_oe[i] : 1'b0;
        n_po[i]  = (md == 2'b01 || md == 2'b11) ? bus.core_out[i] : 1'b0;
        n_ci[i]  = (md == 2'b10 || md == 2'b11) ? (fe ? m_fv[i] : m_s2[i]) : 1'b0;
        hit      = ie && (m_ci[i] != m_prev[i]);
        wclr     = bus.cfg_we && bus.cfg_addr == i && !bus.cfg_wdata[3];
        n_pend[i] = wclr ? 1'b0 : hit ? 1'b1 : bus.irq_clr[i] ? 1'b0 : m_pend[i];
        m_s2w[i] = {m_s2w[i][FL-2:0], m_s2[i]};
        m_enw[i] = {m_enw[i][FL-2:0], fe};
        // filtered value flips once the last FL enabled samples all disagree with it
        n_fv[i]  = !fe ? m_s2[i] : ((&m_enw[i]) && m_s2w[i] == {FL{~m_fv[i]}}) ? ~m_fv[i] : m_fv[i];
      end
      m_prev = m_ci;
      m_ci   = n_ci;
      m_pend = n_pend;
      m_po   = n_po;
      m_poe  = n_poe;
      m_fv   = n_fv;
      m_s2   = m_s1;
      m_s1   = bus.pad_in;
      if (bus.cfg_we && bus.cfg_addr < N) m_cfg[bus.cfg_addr] = bus.cfg_wdata;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd1;
    bus.cfg_wdata = 7'h7f;
    bus.pad_in = '1;
    step();
    step();
    bus.cfg_we = 1'b0;
    bus.pad_in = '0;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.pad_out, bus.pad_oe, bus.core_in, bus.irq_pending} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", {bus.pad_out, bus.pad_oe, bus.core_in, bus.irq_pending});
    end
    checks++;
    if (bus.irq !== 1'b0 || bus.pad_cfg !== '0) begin
      errors++;
      $display("FAIL reset_irq_cfg got irq=%b pad_cfg=%h exp 0", bus.irq, bus.pad_cfg);
    end
    for (int a = 0; a < N; a++) begin
      bus.cfg_addr = 3'(a);
      #1;
      checks++;
      if (bus.cfg_rdata !== '0) begin
        errors++;
        $display("FAIL reset_rdata[%0d] got %h exp 0", a, bus.cfg_rdata);
      end
    end
  endtask

  task automatic test_output();
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd2;
    bus.cfg_wdata = 7'b1010001;
    bus.core_out = 6'b000100;
    step();
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.pad_oe[2] !== 1'b0 || bus.cfg_rdata !== 7'b1010001) begin
      errors++;
      $display("FAIL out_latency got oe=%b rdata=%h exp oe=0 rdata=51", bus.pad_oe[2], bus.cfg_rdata);
    end
    step();
    checks++;
    if (bus.pad_oe[2] !== 1'b1 || bus.pad_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL out_mode got oe=%b out=%b exp 1 1", bus.pad_oe[2], bus.pad_out[2]);
    end
    checks++;
    if (bus.pad_cfg[2*CONFW +: CONFW] !== 3'b101) begin
      errors++;
      $display("FAIL out_pad_cfg got %b exp 101", bus.pad_cfg[2*CONFW +: CONFW]);
    end
  endtask

  task automatic test_input();
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_wdata = 7'b0001010;
    step();
    bus.cfg_we = 1'b0;
    step();
    step();
    bus.pad_in[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (bus.core_in[0] !== (k == 3)) begin
        errors++;
        $display("FAIL in_latency step %0d got %b exp %b", k, bus.core_in[0], k == 3);
      end
    end
    checks++;
    if (bus.irq_pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL in_pend_early got %b exp 0", bus.irq_pending[0]);
    end
    step();
    checks++;
    if (bus.irq_pending[0] !== 1'b1 || bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL in_pend got pend=%b irq=%b exp 1 1", bus.irq_pending[0], bus.irq);
    end
  endtask

  task automatic test_filter();
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd1;
    bus.cfg_wdata = 7'b0000110;
    step();
    bus.cfg_we = 1'b0;
    repeat (4) step();
    bus.pad_in[1] = 1'b1;
    repeat (3) step();
    bus.pad_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (bus.core_in[1] !== 1'b0) begin
        errors++;
        $display("FAIL filt_glitch step %0d got %b exp 0", k, bus.core_in[1]);
      end
    end
    bus.pad_in[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (bus.core_in[1] !== (k == 7)) begin
        errors++;
        $display("FAIL filt_level step %0d got %b exp %b", k, bus.core_in[1], k == 7);
      end
    end
  endtask

  task automatic test_irq_clr();
    bus.pad_in[0] = 1'b0;
    repeat (3) step();
    bus.irq_clr[0] = 1'b1;
    step();
    checks++;
    if (bus.irq_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_set got %b exp 1", bus.irq_pending[0]);
    end
    step();
    bus.irq_clr[0] = 1'b0;
    checks++;
    if (bus.irq_pending[0] !== 1'b0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_plain got pend=%b irq=%b exp 0 0", bus.irq_pending[0], bus.irq);
    end
  endtask

  task automatic test_bidir();
    logic ph [8];
    logic co;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd3;
    bus.cfg_wdata = 7'b0000011;
    step();
    bus.cfg_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      co = 1'($urandom);
      ph[k] = 1'($urandom);
      bus.core_oe[3] = k[0];
      bus.core_out[3] = co;
      bus.pad_in[3] = ph[k];
      step();
      checks++;
      if (bus.pad_oe[3] !== k[0] || bus.pad_out[3] !== co) begin
        errors++;
        $display("FAIL bidir_oe step %0d got oe=%b out=%b exp %b %b", k, bus.pad_oe[3], bus.pad_out[3], k[0], co);
      end
      if (k >= 2) begin
        checks++;
        if (bus.core_in[3] !== ph[k-2]) begin
          errors++;
          $display("FAIL bidir_in step %0d got %b exp %b", k, bus.core_in[3], ph[k-2]);
        end
      end
    end
  endtask

  task automatic test_bad_addr();
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'(N);
    bus.cfg_wdata = 7'h7f;
    step();
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.cfg_rdata !== '0) begin
      errors++;
      $display("FAIL bad_addr_rdata got %h exp 0", bus.cfg_rdata);
    end
    bus.cfg_addr = 3'd7;
    #1;
    checks++;
    if (bus.cfg_rdata !== '0) begin
      errors++;
      $display("FAIL bad_addr7_rdata got %h exp 0", bus.cfg_rdata);
    end
    for (int a = 0; a < N; a++) begin
      bus.cfg_addr = 3'(a);
      #1;
      checks++;
      if (bus.cfg_rdata !== m_cfg[a]) begin
        errors++;
        $display("FAIL bad_addr_keep[%0d] got %h exp %h", a, bus.cfg_rdata, m_cfg[a]);
      end
    end
  endtask

  task automatic test_random();
    logic [N*CONFW-1:0] e_cfg;
    logic [CFG_W-1:0]   e_rd;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_addr = 3'($urandom_range(0, 7));
      bus.cfg_wdata = 7'($urandom);
      bus.core_out = 6'($urandom);
      bus.core_oe = 6'($urandom);
      bus.irq_clr = 6'($urandom & $urandom & $urandom);
      bus.pad_in = bus.pad_in ^ 6'($urandom & $urandom & $urandom);
      step();
      for (int i = 0; i < N; i++) e_cfg[i*CONFW +: CONFW] = m_cfg[i][CFG_W-1:4];
      e_rd = (bus.cfg_addr < N) ? m_cfg[bus.cfg_addr] : '0;
      checks++;
      if (bus.pad_out !== m_po || bus.pad_oe !== m_poe) begin
        errors++;
        $display("FAIL rnd_pad cyc %0d got out=%h oe=%h exp %h %h", c, bus.pad_out, bus.pad_oe, m_po, m_poe);
      end
      checks++;
      if (bus.core_in !== m_ci) begin
        errors++;
        $display("FAIL rnd_core_in cyc %0d got %h exp %h", c, bus.core_in, m_ci);
      end
      checks++;
      if (bus.irq_pending !== m_pend || bus.irq !== (|m_pend)) begin
        errors++;
        $display("FAIL rnd_irq cyc %0d got pend=%h irq=%b exp %h %b", c, bus.irq_pending, bus.irq, m_pend, |m_pend);
      end
      checks++;
      if (bus.pad_cfg !== e_cfg || bus.cfg_rdata !== e_rd) begin
        errors++;
        $display("FAIL rnd_cfg cyc %0d got pad_cfg=%h rdata=%h exp %h %h", c, bus.pad_cfg, bus.cfg_rdata, e_cfg, e_rd);
      end
    end
    rst = 1'b0;
    bus.cfg_we = 1'b0;
    bus.irq_clr = '0;
  endtask

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.core_out = '0;
    bus.core_oe = '0;
    bus.irq_clr = '0;
    bus.pad_in = '0;
    test_reset();
    test_output();
    test_input();
    test_filter();
    test_irq_clr();
    test_bidir();
    test_bad_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bank_ctrl.md
IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IO, default 8: number of pad channels, range 1..32.
REQ-002 The block SHALL have parameter CONF_WIDTH, default 3: per-cell pad configuration width (drive/pull/slew), passed through to cells.
REQ-003 The block SHALL have parameter FILT_LEN, default 4: glitch-filter stability length in cycles, range 2..255.
REQ-004 The block SHALL define CFG_W = 4+CONF_WIDTH and AW = max(1,$clog2(NUM_IO)).
REQ-005 The block SHALL have port clk  input  1  the single block clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port cfg_we  input  1  config write strobe.
REQ-008 The block SHALL have port cfg_addr  input  AW  channel index for write/read.
REQ-009 The block SHALL have port cfg_wdata  input  CFG_W  [1:0] mode, [2] filt_en, [3] irq_en, [CFG_W-1:4] cell_cfg.
REQ-010 The block SHALL have port cfg_rdata  output  CFG_W  combinational readback of cfg[cfg_addr].
REQ-011 The block SHALL have port core_out  input  NUM_IO  core data towards pads.
REQ-012 The block SHALL have port core_oe  input  NUM_IO  core output enable, used in bidir mode only.
REQ-013 The block SHALL have port core_in  output  NUM_IO  synchronised/filtered pad data to core.
REQ-014 The block SHALL have port irq_clr  input  NUM_IO  write-1-to-clear of pending bits.
REQ-015 The block SHALL have port irq_pending  output  NUM_IO  sticky per-channel edge flags.
REQ-016 The block SHALL have port irq  output  1  OR of irq_pending.
REQ-017 The block SHALL have port pad_out  output  NUM_IO  data to io cells.
REQ-018 The block SHALL have port pad_oe  output  NUM_IO  output enable to io cells.
REQ-019 The block SHALL have port pad_in  input  NUM_IO  asynchronous data from io cells.
REQ-020 The block SHALL have port pad_cfg  output  NUM_IO*CONF_WIDTH  cell_cfg of channel i on bits [i*CONF_WIDTH +: CONF_WIDTH].

Function
REQ-021 Mode encoding SHALL be: 00 disabled, 01 output, 10 input, 11 bidir.
REQ-022 A write with cfg_we=1 and cfg_addr<NUM_IO SHALL update cfg[cfg_addr] at the clock edge; writes to cfg_addr>=NUM_IO SHALL be ignored, and reads from such addresses SHALL return 0.
REQ-023 pad_out[i] and pad_oe[i] SHALL be registered with one cycle latency: mode 01 -> oe=1, out=core_out; mode 11 -> oe=core_oe, out=core_out; modes 00/10 -> oe=0, out=0.
REQ-024 pad_in SHALL pass through a 2-flop synchroniser per channel (sync2); the synchroniser SHALL always run regardless of mode.
REQ-025 Filter: counter cnt[i] SHALL reset to 0 whenever sync2==filt_val; otherwise cnt SHALL increment, and on the cycle cnt==FILT_LEN-1 filt_val SHALL load sync2 and cnt SHALL return to 0.
REQ-026 A level held stable SHALL therefore reach filt_val FILT_LEN cycles after it appears on sync2, and any pulse shorter than FILT_LEN cycles SHALL be rejected.
REQ-027 With filt_en=0, filt_val SHALL load sync2 every cycle and cnt SHALL be held at 0, so enabling the filter causes no spurious edge.
REQ-028 core_in[i] SHALL be registered: filt_val (filt_en=1) or sync2 (filt_en=0) in modes 10/11, and 0 in modes 00/01.
REQ-029 Unfiltered latency SHALL be 3 cycles from pad_in change to core_in.
REQ-030 Edge detection: a change of core_in[i] versus its previous-cycle value with irq_en=1 SHALL set irq_pending[i] on the next edge; both edges count, including edges caused by mode changes.
REQ-031 irq_clr[i]=1 SHALL clear irq_pending[i]; when set and clear coincide, set SHALL win.
REQ-032 A config write with irq_en=0 SHALL clear that channel's pending bit, and this clear SHALL take priority over a simultaneous set.
REQ-033 irq SHALL be combinational |irq_pending.

Reset
REQ-034 On rst=1 at a clock edge, all cfg, sync flops, filt_val, cnt, core_in, pad_out, pad_oe and irq_pending SHALL be 0; hence pad_cfg=0 and irq=0.
REQ-035 Reset asserted mid-filter or mid-write SHALL discard the in-progress count or write.

Verification
REQ-036 Bench SHALL check: after reset, all outputs 0; write ch2 cfg=01 with core_out[2]=1 -> pad_oe[2]=1 and pad_out[2]=1 one cycle later.
REQ-037 Bench SHALL check: ch0 mode 10, filt_en=0, irq_en=1; pad_in[0] 0->1 -> core_in[0]=1 after 3 cycles, irq_pending[0]=1 one cycle later, irq=1.
REQ-038 Bench SHALL check, with FILT_LEN=4 and ch1 filtered: a 3-cycle pad pulse -> core_in[1] stays 0; a 4-cycle-stable level -> core_in[1]=1 at 2+4+1 cycles.
REQ-039 Bench SHALL check: irq_clr[0] coinciding with a new edge on ch0 -> irq_pending[0] remains 1; an irq_clr with no edge -> 0.
REQ-040 Bench SHALL check bidir ch3: core_oe toggling -> pad_oe follows one cycle later, and core_in reflects pad_in.
REQ-041 Bench SHALL check: a write to cfg_addr=NUM_IO leaves all cfg unchanged and its readback returns 0.
